pipelined_prefix_adder: RTL and testbench

PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

---
 rtl/pipelined_prefix_adder_pkg.sv | 26 ++
 rtl/pipelined_prefix_adder_prefix_logic.sv | 16 +
 rtl/pipelined_prefix_adder.sv | 194 +++++++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared definitions for the pipelined parallel-prefix adder: operation
// encodings, default geometry and the pipeline-register placement rule.
package pipelined_prefix_adder_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_GROUPSIZE = 4;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_ADDC = 2'd2,
        OP_SUBB = 2'd3
    } op_e;

    // Returns the pipeline stage index registered at prefix boundary bnd, or -1.
    // Register k of pipe sits at boundary ceil(k*levels/(pipe+1)).
    function automatic int stage_at(input int bnd, input int levels, input int pipe);
        int stg;
        stg = -1;
        for (int k = 1; k <= pipe; k++) begin
            stg = (((k * levels + pipe) / (pipe + 1)) == bnd) ? k - 1 : stg;
        end
        return stg;
    endfunction

endpackage

// File: rtl/pipelined_prefix_adder_prefix_logic.sv
// Generate/propagate combine cell used at every node of the prefix tree.
module prefix_logic
    import pipelined_prefix_adder_pkg::*;
(
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);

    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone style group prefix adder with valid/ready pipeline stages spread
// over the prefix levels and an always-present output register.
module pipelined_prefix_adder
    import pipelined_prefix_adder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int GROUPSIZE = DEFAULT_GROUPSIZE,
    parameter int PIPE      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG     = WIDTH / GROUPSIZE;
    localparam int LEVELS = $clog2(NG);
    localparam int NS     = PIPE + 1;
    localparam int PW     = 2 * WIDTH + 1 + 2 * NG;

    logic [NS-1:0] valid_r;
    logic [NS-1:0] up_valid_s;
    logic [NS-1:0] ready_s;
    logic [PW-1:0] bnd_s [0:LEVELS];

    // A stage can take new contents when it is empty or its occupant moves on.
    always_comb begin
        logic r;
        r = out_ready;
        ready_s = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            r = ~valid_r[s] | r;
            ready_s[s] = r;
        end
        up_valid_s = valid_r << 1;
        up_valid_s[0] = in_valid;
    end

    assign in_ready = ready_s[0] & ~rst;

    // Stage valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else begin
            valid_r <= (valid_r & ~ready_s) | (up_valid_s & ready_s);
        end
    end

    logic [WIDTH-1:0] bx_s, g0_s, p0_s;
    logic             c0_s;
    logic [NG-1:0]    gg0_s, gp0_s;

    // Effective second operand and carry-in for each operation.
    always_comb begin
        case (op_e'(op))
            OP_ADD:  begin bx_s = b;  c0_s = 1'b0; end
            OP_SUB:  begin bx_s = ~b; c0_s = 1'b1; end
            OP_ADDC: begin bx_s = b;  c0_s = cin;  end
            OP_SUBB: begin bx_s = ~b; c0_s = cin;  end
            default: begin bx_s = b;  c0_s = 1'b0; end
        endcase
    end

    assign g0_s = a & bx_s;
    assign p0_s = a ^ bx_s;

    // Group generate/propagate; the ripple here never leaves a single group.
    always_comb begin
        logic gacc, pacc;
        gg0_s = '0;
        gp0_s = '0;
        for (int grp = 0; grp < NG; grp++) begin
            gacc = 1'b0;
            pacc = 1'b1;
            for (int t = 0; t < GROUPSIZE; t++) begin
                gacc = g0_s[grp*GROUPSIZE+t] | (p0_s[grp*GROUPSIZE+t] & gacc);
                pacc = pacc & p0_s[grp*GROUPSIZE+t];
            end
            gg0_s[grp] = gacc;
            gp0_s[grp] = pacc;
        end
    end

    assign bnd_s[0] = {p0_s, g0_s, c0_s, gg0_s, gp0_s};

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int D   = 1 << l;
        localparam int STG = stage_at(l + 1, LEVELS, PIPE);

        logic [NG-1:0]      gi_s, pi_s, go_s, po_s;
        logic [PW-2*NG-1:0] pass_s;
        logic [PW-1:0]      nxt_s;

        assign {pass_s, gi_s, pi_s} = bnd_s[l];

        for (genvar i = 0; i < NG; i++) begin : g_node
            if (i >= D) begin : g_cell
                prefix_logic u_cell (
                    .g_hi (gi_s[i]),
                    .p_hi (pi_s[i]),
                    .g_lo (gi_s[i-D]),
                    .p_lo (pi_s[i-D]),
                    .g    (go_s[i]),
                    .p    (po_s[i])
                );
            end else begin : g_pass
                assign go_s[i] = gi_s[i];
                assign po_s[i] = pi_s[i];
            end
        end

        assign nxt_s = {pass_s, go_s, po_s};

        if (STG >= 0) begin : g_reg
            logic [PW-1:0] data_r;
            // Internal pipeline register between prefix levels.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_r <= '0;
                end else if (ready_s[STG] && up_valid_s[STG]) begin
                    data_r <= nxt_s;
                end else begin
                    data_r <= data_r;
                end
            end
            assign bnd_s[l+1] = data_r;
        end else begin : g_comb
            assign bnd_s[l+1] = nxt_s;
        end
    end

    logic [WIDTH-1:0] pf_s, gf_s, sum_nx_s;
    logic             cf_s, c_msb_s;
    logic [NG-1:0]    ggf_s, gpf_s;
    logic [NG:0]      cg_s;

    assign {pf_s, gf_s, cf_s, ggf_s, gpf_s} = bnd_s[LEVELS];
    assign cg_s = {ggf_s | (gpf_s & {NG{cf_s}}), cf_s};

    // Sum bits from group carry-ins; only bits inside a group ripple.
    always_comb begin
        logic c;
        sum_nx_s = '0;
        c_msb_s  = 1'b0;
        c        = 1'b0;
        for (int grp = 0; grp < NG; grp++) begin
            c = cg_s[grp];
            for (int t = 0; t < GROUPSIZE; t++) begin
                sum_nx_s[grp*GROUPSIZE+t] = pf_s[grp*GROUPSIZE+t] ^ c;
                c_msb_s = c;
                c = gf_s[grp*GROUPSIZE+t] | (pf_s[grp*GROUPSIZE+t] & c);
            end
        end
    end

    logic [WIDTH-1:0] sum_r;
    logic             cout_r, ovf_r;

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (ready_s[PIPE] && up_valid_s[PIPE]) begin
            sum_r  <= sum_nx_s;
            cout_r <= cg_s[NG];
            ovf_r  <= c_msb_s ^ cg_s[NG];
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
            ovf_r  <= ovf_r;
        end
    end

    assign out_valid = valid_r[PIPE];
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    // Zero is derived from the registered sum and qualified so it reads 0 when idle.
    assign zero      = valid_r[PIPE] & ~|sum_r;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed and randomized checks of pipelined_prefix_adder at PIPE 0, 1 and 3
// against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_prefix_adder;

    typedef struct {
        int          inst;
        logic [34:0] res;
    } exp_t;

    logic        clk, rst;
    logic        in_valid_v [3];
    logic        in_ready_v [3];
    logic        cin_v [3];
    logic        out_valid_v [3];
    logic        out_ready_v [3];
    logic        cout_v [3];
    logic        ovf_v [3];
    logic        zero_v [3];
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [31:0] sum_v [3];
    logic [1:0]  op_v [3];

    int          n_cmp, n_err;
    int          occ [3];
    int          acc [3];
    int          cons [3];
    logic        stall_prev [3];
    logic [34:0] held [3];
    exp_t        expq [$];

    for (genvar j = 0; j < 3; j++) begin : g_dut
        pipelined_prefix_adder #(
            .WIDTH     (32),
            .GROUPSIZE (4),
            .PIPE      (j == 0 ? 0 : (j == 1 ? 1 : 3))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[j]),
            .in_ready  (in_ready_v[j]),
            .a         (a_v[j]),
            .b         (b_v[j]),
            .cin       (cin_v[j]),
            .op        (op_v[j]),
            .out_valid (out_valid_v[j]),
            .out_ready (out_ready_v[j]),
            .sum       (sum_v[j]),
            .cout      (cout_v[j]),
            .ovf       (ovf_v[j]),
            .zero      (zero_v[j])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pipe_of(input int j);
        return (j == 0) ? 0 : ((j == 1) ? 1 : 3);
    endfunction

    // Reference: {zero, ovf, cout, sum} from plain 33-bit arithmetic.
    function automatic logic [34:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
        logic [31:0] bx;
        logic        c, o;
        logic [32:0] full;
        case (op)
            2'd0:    begin bx = b;  c = 1'b0; end
            2'd1:    begin bx = ~b; c = 1'b1; end
            2'd2:    begin bx = b;  c = cin;  end
            default: begin bx = ~b; c = cin;  end
        endcase
        full = {1'b0, a} + {1'b0, bx} + {32'd0, c};
        o = (a[31] == bx[31]) && (full[31] != a[31]);
        return {full[31:0] == 32'd0, o, full[32], full[31:0]};
    endfunction

    function automatic logic [34:0] obs_of(input int j);
        return {zero_v[j], ovf_v[j], cout_v[j], sum_v[j]};
    endfunction

    function automatic int find_exp(input int j);
        for (int i = 0; i < expq.size(); i++) begin
            if (expq[i].inst == j) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rand(input int j);
        in_valid_v[j]  = ($urandom_range(0, 3) != 0);
        out_ready_v[j] = ($urandom_range(0, 2) != 0);
        a_v[j]   = pick();
        b_v[j]   = pick();
        op_v[j]  = 2'($urandom_range(0, 3));
        cin_v[j] = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int j);
        in_valid_v[j]  = 1'b0;
        out_ready_v[j] = 1'b1;
    endtask

    // Called at the falling edge: checks and books the transfers of the next rising edge.
    task automatic score();
        exp_t e;
        int   idx;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("in_ready_p%0d", pipe_of(j)), 64'(in_ready_v[j]),
                64'((occ[j] < pipe_of(j) + 1) || out_ready_v[j]));
            if (stall_prev[j]) begin
                chk($sformatf("hold_valid_p%0d", pipe_of(j)), 64'(out_valid_v[j]), 64'd1);
                chk($sformatf("hold_data_p%0d", pipe_of(j)), 64'(obs_of(j)), 64'(held[j]));
            end
            if (out_valid_v[j] && out_ready_v[j]) begin
                idx = find_exp(j);
                chk($sformatf("result_pending_p%0d", pipe_of(j)), 64'(idx >= 0), 64'd1);
                if (idx >= 0) begin
                    chk($sformatf("result_p%0d", pipe_of(j)), 64'(obs_of(j)), 64'(expq[idx].res));
                    expq.delete(idx);
                    cons[j]++;
                    occ[j]--;
                end
            end
            if (in_valid_v[j] && in_ready_v[j]) begin
                e.inst = j;
                e.res  = model(op_v[j], a_v[j], b_v[j], cin_v[j]);
                expq.push_back(e);
                acc[j]++;
                occ[j]++;
            end
            stall_prev[j] = out_valid_v[j] && !out_ready_v[j];
            held[j] = obs_of(j);
        end
    endtask

    // Single operation on the PIPE=1 instance with latency measurement.
    task automatic run_one(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic cin, input logic [34:0] exp);
        int lat;
        @(posedge clk); #1;
        in_valid_v[1] = 1'b1; op_v[1] = op; a_v[1] = a; b_v[1] = b; cin_v[1] = cin;
        out_ready_v[1] = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready_v[1]), 64'd1);
        @(posedge clk); #1;
        in_valid_v[1] = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (out_valid_v[1]) break;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd2);
        chk({tag, "_result"}, 64'(obs_of(1)), 64'(exp));
        @(posedge clk);
    endtask

    initial begin
        logic saw_low;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            idle(j);
            a_v[j] = 32'd0; b_v[j] = 32'd0; op_v[j] = 2'd0; cin_v[j] = 1'b0;
            occ[j] = 0; acc[j] = 0; cons[j] = 0; stall_prev[j] = 1'b0; held[j] = 35'd0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            chk("rst_out_valid", 64'(out_valid_v[j]), 64'd0);
            chk("rst_outputs", 64'(obs_of(j)), 64'd0);
            chk("rst_in_ready", 64'(in_ready_v[j]), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 3; j++) chk("post_rst_in_ready", 64'(in_ready_v[j]), 64'd1);

        // Directed corner cases, expected values {zero, ovf, cout, sum}
        run_one("add_wrap",  2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
        run_one("sub_neg",   2'd1, 32'd5,         32'd7,         1'b0, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
        run_one("sub_ovf",   2'd1, 32'h8000_0000, 32'd1,         1'b0, {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF});
        run_one("add_ovf",   2'd0, 32'h7FFF_FFFF, 32'd1,         1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
        run_one("addc_cin",  2'd2, 32'h0000_000F, 32'h0000_0010, 1'b1, {1'b0, 1'b0, 1'b0, 32'h0000_0020});
        run_one("subb_cin0", 2'd3, 32'd5,         32'd3,         1'b0, {1'b0, 1'b0, 1'b1, 32'h0000_0001});

        // Backpressure: six back-to-back ops, consumer stalled in cycles 2-5
        saw_low = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 40 && cons[1] < 6; c++) begin
            in_valid_v[1]  = (acc[1] < 6);
            out_ready_v[1] = !(c >= 2 && c <= 5);
            a_v[1] = pick(); b_v[1] = pick();
            op_v[1] = 2'($urandom_range(0, 3)); cin_v[1] = 1'($urandom_range(0, 1));
            @(negedge clk);
            score();
            if (!in_ready_v[1]) saw_low = 1'b1;
            @(posedge clk); #1;
        end
        in_valid_v[1] = 1'b0;
        out_ready_v[1] = 1'b1;
        chk("bp_results", 64'(cons[1]), 64'd6);
        chk("bp_in_ready_low", 64'(saw_low), 64'd1);

        // Reset with two operations in flight
        in_valid_v[1] = 1'b1; out_ready_v[1] = 1'b0;
        a_v[1] = 32'd1; b_v[1] = 32'd2; op_v[1] = 2'd0;
        @(negedge clk);
        chk("mid_rst_accept0", 64'(in_ready_v[1]), 64'd1);
        @(posedge clk); #1;
        a_v[1] = 32'd3;
        @(negedge clk);
        chk("mid_rst_accept1", 64'(in_ready_v[1]), 64'd1);
        @(posedge clk); #1;
        in_valid_v[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready_v[1]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready_v[1] = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid_v[1]), 64'd0);
        chk("mid_rst_in_ready_after", 64'(in_ready_v[1]), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mid_rst_no_result", 64'(out_valid_v[1]), 64'd0);
        end
        for (int j = 0; j < 3; j++) begin
            stall_prev[j] = 1'b0;
            occ[j] = 0;
        end

        // Randomized traffic on all three pipeline depths
        @(posedge clk); #1;
        for (int c = 0; c < 500; c++) begin
            for (int j = 0; j < 3; j++) drive_rand(j);
            @(negedge clk);
            score();
            @(posedge clk); #1;
        end
        for (int j = 0; j < 3; j++) idle(j);
        for (int c = 0; c < 100 && expq.size() > 0; c++) begin
            @(negedge clk);
            score();
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(expq.size()), 64'd0);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("count_p%0d", pipe_of(j)), 64'(cons[j]), 64'(acc[j]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
